// File: rtl/ldl_rr_pri_arb_pkg.sv
// Shared constants for the round-robin / fixed-priority arbiter: mode selectors,
// two-state view of the output register, and a vector rotate helper.
package ldl_arb_pkg;

  localparam int LDL_ARB_FIXED = 0;
  localparam int LDL_ARB_RR    = 1;

  localparam logic [0:0] ARB_EMPTY = 1'b0;
  localparam logic [0:0] ARB_FULL  = 1'b1;

  // Rotate the low n bits of v left by sh positions; bits at and above n are zero.
  function automatic logic [63:0] ldl_rotl(input logic [63:0] v,
                                           input int unsigned sh,
                                           input int unsigned n);
    logic [63:0] r;
    r = '0;
    if (n != 0) begin
      for (int unsigned i = 0; i < 64; i++) begin
        if (i < n) r[6'((i + sh) % n)] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ldl_rr_pri_arb_if.sv
// Request/grant bundle between request sources, the arbiter and the grant consumer.
interface ldl_rr_pri_arb_if #(
  parameter int BIN_WIDTH = 3
);
  logic [(1<<BIN_WIDTH)-1:0] x;
  logic [BIN_WIDTH-1:0]      y;
  logic                      valid;
  logic                      ready;

  // Handshake: a grant transfers on a cycle where valid & ready are both high.
  // Once valid rises, y and valid stay frozen until that transfer; ready while
  // valid is low has no effect, and x is sampled only when the register loads.
  modport master (input x, input ready, output y, output valid);
  modport slave  (output x, output ready, input y, input valid);
endinterface

// File: rtl/ldl_pri_enc_mask.sv
// Wrapped priority encoder: first set request at or above start, modulo N,
// found by a masked lowest-set search over the request vector doubled up.
module ldl_pri_enc_mask #(
  parameter int BIN_WIDTH = 3
) (
  input  logic [(1<<BIN_WIDTH)-1:0] req,
  input  logic [BIN_WIDTH-1:0]      start,
  output logic [BIN_WIDTH-1:0]      idx,
  output logic                      any
);
  localparam int N = 1 << BIN_WIDTH;

  logic [2*N-1:0] dbl;
  logic           found;

  assign dbl = {req, req};
  assign any = |req;

  // Positions below start are masked; the upper copy supplies the wrap-around.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (!found && dbl[i] && (i >= int'(start))) begin
        found = 1'b1;
        idx   = BIN_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/ldl_rr_pri_arb.sv
// Registered priority arbiter with a held grant under back-pressure; fixed
// priority or round-robin selected by RR_MODE.
module ldl_rr_pri_arb
  import ldl_arb_pkg::*;
#(
  parameter int BIN_WIDTH = 3,
  parameter int RR_MODE   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ldl_rr_pri_arb_if.master     bus,
  output logic [0:0]           dbg_state,
  output logic [BIN_WIDTH-1:0] dbg_ptr
);

  logic                 valid_q;
  logic [BIN_WIDTH-1:0] y_q;
  logic [BIN_WIDTH-1:0] ptr_q;
  logic                 accept;
  logic                 load;
  logic [BIN_WIDTH-1:0] start;
  logic [BIN_WIDTH-1:0] win;
  logic                 any;

  assign accept = valid_q & bus.ready;
  assign load   = !valid_q | bus.ready;

  // On acceptance ptr_q is still stale, so the next search starts from y+1 directly.
  always_comb begin
    start = '0;
    if (RR_MODE == LDL_ARB_RR) begin
      start = accept ? (y_q + BIN_WIDTH'(1)) : ptr_q;
    end
  end

  ldl_pri_enc_mask #(.BIN_WIDTH(BIN_WIDTH)) u_enc (
    .req   (bus.x),
    .start (start),
    .idx   (win),
    .any   (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      ptr_q   <= '0;
    end else begin
      if (load) begin
        valid_q <= any;
        if (any) y_q <= win;
      end
      if (accept) ptr_q <= y_q + BIN_WIDTH'(1);
    end
  end

  assign bus.valid = valid_q;
  assign bus.y     = y_q;
  assign dbg_state = valid_q ? ARB_FULL : ARB_EMPTY;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_ldl_rr_pri_arb.sv
// Bench for ldl_rr_pri_arb: a fixed-priority and a round-robin instance share
// stimulus; directed vectors plus random traffic against a behavioural model.
module tb_ldl_rr_pri_arb;
  localparam int BW = 3;
  localparam int N  = 1 << BW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] x;
  logic         ready;
  logic [0:0]   st_fx, st_rr;
  logic [BW-1:0] ptr_fx, ptr_rr;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  ldl_rr_pri_arb_if #(.BIN_WIDTH(BW)) if_fx ();
  ldl_rr_pri_arb_if #(.BIN_WIDTH(BW)) if_rr ();

  assign if_fx.x = x;
  assign if_fx.ready = ready;
  assign if_rr.x = x;
  assign if_rr.ready = ready;

  ldl_rr_pri_arb #(.BIN_WIDTH(BW), .RR_MODE(0)) dut_fx (
    .clk (clk), .rst_n (rst_n), .bus (if_fx.master),
    .dbg_state (st_fx), .dbg_ptr (ptr_fx)
  );
  ldl_rr_pri_arb #(.BIN_WIDTH(BW), .RR_MODE(1)) dut_rr (
    .clk (clk), .rst_n (rst_n), .bus (if_rr.master),
    .dbg_state (st_rr), .dbg_ptr (ptr_rr)
  );

  // Reference model: index 0 = fixed, index 1 = round-robin.
  int m_valid[2];
  int m_y[2];
  int m_ptr[2];

  function automatic int pick(input int rr, input logic [N-1:0] xv, input int start);
    int s;
    s = rr ? start : 0;
    for (int k = 0; k < N; k++) begin
      if (xv[(s + k) % N]) return (s + k) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_y[m] = 0; m_ptr[m] = 0;
    end
  endtask

  // Grant leaving on this edge moves the pointer past it before the next pick.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (m_valid[m] != 0 && ready) m_ptr[m] = (m_y[m] + 1) % N;
      if (m_valid[m] == 0 || ready) begin
        if (x != 0) begin
          m_valid[m] = 1;
          m_y[m] = pick(m, x, m_ptr[m]);
        end else begin
          m_valid[m] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("fx_valid", int'(if_fx.valid), m_valid[0]);
    chk("fx_y",     int'(if_fx.y),     m_y[0]);
    chk("fx_ptr",   int'(ptr_fx),      m_ptr[0]);
    chk("fx_state", int'(st_fx),       m_valid[0]);
    chk("rr_valid", int'(if_rr.valid), m_valid[1]);
    chk("rr_y",     int'(if_rr.y),     m_y[1]);
    chk("rr_ptr",   int'(ptr_rr),      m_ptr[1]);
    chk("rr_state", int'(st_rr),       m_valid[1]);
  endtask

  // driver: inputs change on the falling edge, outputs sampled on the next one
  task automatic step(input logic [N-1:0] xi, input logic ri);
    x = xi;
    ready = ri;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_models();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_models();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] x;
    logic         ready;
    logic         rr;
    logic         exp_v;
    logic [BW-1:0] exp_y;
  } vec_t;

  vec_t tbl[$];
  logic [BW:0] exp_q[$];

  function automatic vec_t mk(input logic r, input logic [N-1:0] xv, input logic rd,
                              input logic rr, input logic ev, input int ey);
    vec_t v;
    v.rst = r; v.x = xv; v.ready = rd; v.rr = rr; v.exp_v = ev; v.exp_y = BW'(ey);
    return v;
  endfunction

  initial begin
    logic [BW:0] exp;
    logic [BW:0] got;
    rst_n = 1'b0;
    x = '1;
    ready = 1'b1;
    model_reset();

    // Reset with all requests asserted, then first grant one cycle after release.
    @(posedge clk);
    @(negedge clk);
    chk("rst_fx_valid", int'(if_fx.valid), 0);
    chk("rst_fx_y",     int'(if_fx.y),     0);
    chk("rst_rr_valid", int'(if_rr.valid), 0);
    chk("rst_rr_y",     int'(if_rr.y),     0);
    rst_n = 1'b1;
    step(8'hFF, 1'b1);
    chk("rel_rr_valid", int'(if_rr.valid), 1);
    chk("rel_rr_y",     int'(if_rr.y),     0);

    // Fixed priority
    tbl.push_back(mk(1, 8'b1010_0100, 1, 0, 1, 2));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 8'b1010_0100, 1, 0, 1, 2));
    tbl.push_back(mk(0, 8'b1010_0000, 1, 0, 1, 5));
    // Round-robin sweep
    for (int i = 0; i < 10; i++) tbl.push_back(mk(i == 0, 8'hFF, 1, 1, 1, i % N));
    // Back-pressure
    tbl.push_back(mk(1, 8'b1000_0001, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'b1000_0001, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'b1000_0001, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h80, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h80, 1, 1, 1, 7));
    tbl.push_back(mk(0, 8'h80, 1, 1, 1, 7));
    // Drain and wrap: grant 6 accepted leaves ptr at 7
    tbl.push_back(mk(0, 8'h40, 1, 1, 1, 6));
    tbl.push_back(mk(0, 8'b1000_0001, 1, 1, 1, 7));
    tbl.push_back(mk(0, 8'b1000_0001, 1, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      exp_q.push_back({tbl[i].exp_v, tbl[i].exp_y});
      step(tbl[i].x, tbl[i].ready);
      exp = exp_q.pop_front();
      got = tbl[i].rr ? {if_rr.valid, if_rr.y} : {if_fx.valid, if_fx.y};
      chk($sformatf("vec%0d", i), int'(got), int'(exp));
    end

    // Asynchronous reset while a grant of 5 is held
    step(8'h20, 1'b1);
    chk("hold_y", int'(if_rr.y), 5);
    step(8'h20, 1'b0);
    chk("hold_y2", int'(if_rr.y), 5);
    chk("hold_v2", int'(if_rr.valid), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", int'(if_rr.valid), 0);
    chk("arst_y",     int'(if_rr.y),     0);
    chk("arst_ptr",   int'(ptr_rr),      0);
    #1 rst_n = 1'b1;
    step(8'hFF, 1'b1);
    chk("arst_rel_y", int'(if_rr.y), 0);
    chk("arst_rel_v", int'(if_rr.valid), 1);

    // Random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      int r;
      logic [N-1:0] xr;
      if (c % 97 == 96) do_reset();
      r = $urandom_range(0, 3);
      if (r == 0)      xr = '0;
      else if (r == 1) xr = N'(1) << $urandom_range(0, N-1);
      else             xr = N'($urandom_range(0, (1<<N)-1));
      step(xr, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
